// File: rtl/softmax_normalizer_if.sv
// -----------------------------------------------------------------------------
// softmax_normalizer_if
//
// Bundles the input and output handshakes of the softmax normalizer.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. A producer holds valid and its payload stable
// until that edge. A consumer may raise or lower ready at any time. Ready never
// depends combinationally on valid.
//
// Signals:
//   in_valid / in_ready   : input handshake (exp1..exp5, den_in payload)
//   exp1..exp5            : {exponent[20:16], mantissa[15:0]}
//   den_in                : {highest[36:32], sum[31:12], 12'b0}
//   out_valid / out_ready : output handshake (prob1..prob5 payload)
//   prob1..prob5          : unsigned Q0.FRAC_W probabilities
//   busy                  : high from input acceptance until out_valid rises
//
// Modports:
//   master : the environment side (drives inputs, consumes results)
//   slave  : the normalizer side
// -----------------------------------------------------------------------------
interface softmax_normalizer_if #(
    parameter int FRAC_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [20:0]       exp1;
    logic [20:0]       exp2;
    logic [20:0]       exp3;
    logic [20:0]       exp4;
    logic [20:0]       exp5;
    logic [36:0]       den_in;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] prob1;
    logic [FRAC_W-1:0] prob2;
    logic [FRAC_W-1:0] prob3;
    logic [FRAC_W-1:0] prob4;
    logic [FRAC_W-1:0] prob5;
    logic              busy;

    modport master (
        output in_valid, exp1, exp2, exp3, exp4, exp5, den_in, out_ready,
        input  in_ready, out_valid, prob1, prob2, prob3, prob4, prob5, busy
    );

    modport slave (
        input  in_valid, exp1, exp2, exp3, exp4, exp5, den_in, out_ready,
        output in_ready, out_valid, prob1, prob2, prob3, prob4, prob5, busy
    );
endinterface

// File: rtl/softmax_normalizer.sv
// -----------------------------------------------------------------------------
// softmax_normalizer
//
// Final softmax stage. Takes five block-floating exponentials and the packed
// denominator {highest, sum} from the denominator block and produces five
// Q0.FRAC_W probabilities. One restoring divider is shared by the five elements
// and processes them one after another, so latency is fixed at
// 5*(FRAC_W+1) cycles from acceptance to out_valid.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : softmax_normalizer_if.slave (handshakes, operands, results)
//   state_dbg : current FSM state (IDLE=0, LOAD=1, DIV=2, DONE=3)
// -----------------------------------------------------------------------------
module softmax_normalizer #(
    parameter int FRAC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    softmax_normalizer_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int CNT_W = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [20:0]       exp_q [5];
    logic [4:0]        highest_q;
    logic [19:0]       den_q;
    logic [2:0]        idx;
    logic [CNT_W-1:0]  cnt;
    logic [20:0]       rem_q;
    logic [FRAC_W-1:0] quo_q;
    logic              zero_q;
    logic              sat_q;
    logic [FRAC_W-1:0] prob_q [5];
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    // Low 12 bits of den_in carry no information.
    logic den_lsb_unused;
    assign den_lsb_unused = ^bus.den_in[11:0];

    // Alignment of the current element onto the common (highest) exponent.
    logic [20:0] cur_exp;
    logic [4:0]  cur_e;
    logic [15:0] cur_m;
    logic [4:0]  shift;
    logic [15:0] num;

    // One restoring-division step.
    logic [21:0]       trial;
    logic [20:0]       diff;
    logic              ge;
    logic [20:0]       rem_nxt;
    logic [FRAC_W-1:0] quo_nxt;

    always_comb begin
        cur_exp = exp_q[idx];
        cur_e   = cur_exp[20:16];
        cur_m   = cur_exp[15:0];
        // An element above the reported maximum is treated as unshifted.
        shift   = (cur_e > highest_q) ? 5'd0 : (highest_q - cur_e);
        num     = (shift >= 5'd16) ? 16'd0 : (cur_m >> shift);

        trial   = {rem_q, 1'b0};
        // Only the low 21 bits of the difference are ever kept.
        diff    = trial[20:0] - {1'b0, den_q};
        ge      = (trial >= {2'b00, den_q});
        rem_nxt = ge ? diff : trial[20:0];
        quo_nxt = {quo_q[FRAC_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int i = 0; i < 5; i++) begin
                exp_q[i]  <= '0;
                prob_q[i] <= '0;
            end
            highest_q   <= '0;
            den_q       <= '0;
            idx         <= '0;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            zero_q      <= 1'b0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        exp_q[0]   <= bus.exp1;
                        exp_q[1]   <= bus.exp2;
                        exp_q[2]   <= bus.exp3;
                        exp_q[3]   <= bus.exp4;
                        exp_q[4]   <= bus.exp5;
                        highest_q  <= bus.den_in[36:32];
                        den_q      <= bus.den_in[31:12];
                        idx        <= 3'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= LOAD;
                    end
                end

                LOAD: begin
                    rem_q  <= {5'd0, num};
                    quo_q  <= '0;
                    // Division by zero outranks saturation.
                    zero_q <= (den_q == 20'd0);
                    sat_q  <= (den_q != 20'd0) && ({4'd0, num} >= den_q);
                    cnt    <= '0;
                    state  <= DIV;
                end

                DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (zero_q)
                            prob_q[idx] <= '0;
                        else if (sat_q)
                            prob_q[idx] <= '1;
                        else
                            prob_q[idx] <= quo_nxt;

                        if (idx == 3'd4) begin
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= LOAD;
                        end
                    end
                end

                DONE: begin
                    // Re-arm in_ready only after leaving DONE, so a new
                    // transaction cannot be taken on the same edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.prob1     = prob_q[0];
    assign bus.prob2     = prob_q[1];
    assign bus.prob3     = prob_q[2];
    assign bus.prob4     = prob_q[3];
    assign bus.prob5     = prob_q[4];
    assign state_dbg     = state;

endmodule

// File: tb/tb_softmax_normalizer.sv
// -----------------------------------------------------------------------------
// tb_softmax_normalizer
//
// Bench for softmax_normalizer: fixed vectors with hand-derived probabilities,
// a few randomised vectors scored by a reference model, backpressure with
// ignored input pulses, and an asynchronous reset in the middle of a division.
// -----------------------------------------------------------------------------
module tb_softmax_normalizer;
    localparam int FRAC_W  = 16;
    localparam int LATENCY = 5 * (FRAC_W + 1);
    localparam int N_FIXED = 5;
    localparam int N_RAND  = 4;
    localparam int N_VEC   = N_FIXED + N_RAND;

    typedef struct packed {
        logic [4:0][20:0] e;    // e[0] = exp1
        logic [36:0]      den;
        logic [4:0][15:0] p;    // p[0] = prob1
    } vec_t;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    softmax_normalizer_if #(.FRAC_W(FRAC_W)) bus ();

    softmax_normalizer #(.FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [79:0] exp_q[$];
    int          n_vec;
    int          n_err;
    vec_t        tbl [N_VEC];

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic logic [79:0] probs_now();
        return {bus.prob5, bus.prob4, bus.prob3, bus.prob2, bus.prob1};
    endfunction

    // Reference: align, then floor(N * 2^16 / D) with zero/saturation rules.
    function automatic logic [15:0] model_prob(input logic [20:0] e, input logic [36:0] den);
        int          s;
        logic [15:0] n;
        logic [19:0] d;
        longint      q;
        d = den[31:12];
        if (e[20:16] > den[36:32]) s = 0;
        else                        s = int'(den[36:32]) - int'(e[20:16]);
        n = (s >= 16) ? 16'd0 : (e[15:0] >> s);
        if (d == 20'd0) return 16'd0;
        if ({4'd0, n} >= d) return 16'hFFFF;
        q = (longint'(n) << 16) / longint'(d);
        return q[15:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_inputs(input vec_t v);
        bus.exp1   = v.e[0];
        bus.exp2   = v.e[1];
        bus.exp3   = v.e[2];
        bus.exp4   = v.e[3];
        bus.exp5   = v.e[4];
        bus.den_in = v.den;
    endtask

    // Offers v, waits for acceptance, pushes the expected result.
    task automatic accept(input vec_t v);
        int w;
        drive_inputs(v);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_ready", {79'd0, bus.in_ready}, 80'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(v.p);
    endtask

    // Full transaction: latency, results, optional backpressure and noise.
    task automatic run_txn(input string name, input vec_t v, input int hold, input bit noise);
        int          lat;
        logic [79:0] want;
        logic [79:0] snap;
        accept(v);
        check({name, "_busy"}, {78'd0, bus.busy, bus.in_ready}, 80'd2);

        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.exp1     = 21'($urandom_range(0, 21'h1FFFFF));
                bus.den_in   = {5'd1, 20'($urandom_range(0, 20'hFFFFF)), 12'd0};
            end
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 80'(lat), 80'(LATENCY));
        check({name, "_busy_done"}, {78'd0, bus.busy, bus.in_ready}, 80'd0);

        want = exp_q.pop_front();
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_prob%0d", name, i + 1), 80'(probs_now()[i*16 +: 16]), 80'(want[i*16 +: 16]));

        snap = probs_now();
        for (int c = 0; c < hold; c++) begin
            if (noise) bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({name, "_hold"}, {bus.out_valid, bus.in_ready, probs_now()[77:0]},
                  {1'b1, 1'b0, snap[77:0]});
            check({name, "_hold_hi"}, 80'(probs_now()[79:78]), 80'(snap[79:78]));
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_release"}, {77'd0, bus.out_valid, bus.in_ready, bus.busy}, 80'd2);
        check({name, "_idle_state"}, 80'(state_dbg), 80'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int   h;
        int   quiet;
        vec_t v;

        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.exp1 = '0; bus.exp2 = '0; bus.exp3 = '0; bus.exp4 = '0; bus.exp5 = '0;
        bus.den_in = '0;

        // 1: all equal
        tbl[0].e   = {5{5'd3, 16'h8000}};
        tbl[0].den = {5'd3, 20'h28000, 12'h0};
        tbl[0].p   = {5{16'h3333}};
        // 2: mixed exponents
        tbl[1].e   = {{5'd4, 16'h0000}, {5'd4, 16'h0000}, {5'd4, 16'h0000},
                      {5'd3, 16'h8000}, {5'd4, 16'h8000}};
        tbl[1].den = {5'd4, 20'h0C000, 12'h0};
        tbl[1].p   = {16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'hAAAA};
        // 3a: N==D saturates, shifted element, exponent above highest
        tbl[2].e   = {{5'd3, 16'h0001}, {5'd2, 16'h7FFF}, {5'd1, 16'h8000},
                      {5'd0, 16'hFFFF}, {5'd2, 16'hFFFF}};
        tbl[2].den = {5'd2, 20'h0FFFF, 12'h0};
        tbl[2].p   = {16'h0001, 16'h7FFF, 16'h4000, 16'h3FFF, 16'hFFFF};
        // 3b: shift of 16 or more clears the numerator; bits [11:0] ignored
        tbl[3].e   = {{5'd0, 16'hFFFF}, {5'd5, 16'hFFFF}, {5'd20, 16'h0008},
                      {5'd4, 16'hFFFF}, {5'd0, 16'h0001}};
        tbl[3].den = {5'd20, 20'h00010, 12'hABC};
        tbl[3].p   = {16'h0000, 16'h1000, 16'h8000, 16'h0000, 16'h0000};
        // 4: zero denominator beats saturation
        tbl[4].e   = {{5'd1, 16'hFFFF}, {5'd1, 16'h1234}, {5'd0, 16'h8000},
                      {5'd1, 16'h0001}, {5'd1, 16'h0000}};
        tbl[4].den = {5'd1, 20'h00000, 12'h0};
        tbl[4].p   = {5{16'h0000}};
        // randomised vectors, scored by the reference model
        for (int k = N_FIXED; k < N_VEC; k++) begin
            h = $urandom_range(0, 20);
            for (int i = 0; i < 5; i++)
                tbl[k].e[i] = {5'($urandom_range(0, h + 2)), 16'($urandom_range(0, 16'hFFFF))};
            tbl[k].den = {5'(h), 20'($urandom_range(1, 20'h3FFFF)), 12'd0};
            for (int i = 0; i < 5; i++)
                tbl[k].p[i] = model_prob(tbl[k].e[i], tbl[k].den);
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {77'd0, bus.in_ready, bus.out_valid, bus.busy}, 80'd4);
        check("reset_probs", probs_now(), 80'd0);
        check("reset_state", 80'(state_dbg), 80'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven pass
        for (int k = 0; k < N_VEC; k++)
            run_txn($sformatf("vec%0d", k), tbl[k], 0, 1'b0);

        // backpressure with ignored input pulses, then a clean follow-up
        run_txn("bp", tbl[1], 10, 1'b1);
        run_txn("bp_next", tbl[0], 0, 1'b0);

        // asynchronous reset part way through the division
        accept(tbl[1]);
        repeat (39) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {77'd0, bus.in_ready, bus.out_valid, bus.busy}, 80'd4);
        check("midrst_probs", probs_now(), 80'd0);
        check("midrst_state", 80'(state_dbg), 80'd0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < LATENCY + 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) quiet++;
        end
        check("midrst_no_output", 80'(quiet), 80'd0);
        run_txn("after_rst", tbl[0], 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
